// File: rtl/traffic_pkg.sv
// Shared definitions for the timed highway/country intersection controller:
// lamp colours, state encoding and elaboration-time helpers.
package traffic_pkg;

   localparam logic [1:0] RED    = 2'd0;
   localparam logic [1:0] YELLOW = 2'd1;
   localparam logic [1:0] GREEN  = 2'd2;
   localparam logic [1:0] OFF    = 2'd3;

   typedef enum logic [2:0] {
      HG  = 3'd0,
      HY  = 3'd1,
      AR1 = 3'd2,
      CG  = 3'd3,
      CY  = 3'd4,
      AR2 = 3'd5,
      FL  = 3'd6
   } state_t;

   function automatic int clog2_f(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'sd1 <<< i) < value) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

   function automatic int max_f(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Returns {highway, country} lamp colours for a state; off selects the dark FL half.
   function automatic logic [3:0] lamps_f(input state_t s, input logic off);
      logic [3:0] l;
      case (s)
         HG:      l = {GREEN, RED};
         HY:      l = {YELLOW, RED};
         AR1:     l = {RED, RED};
         CG:      l = {RED, GREEN};
         CY:      l = {RED, YELLOW};
         AR2:     l = {RED, RED};
         FL:      l = off ? {OFF, OFF} : {YELLOW, YELLOW};
         default: l = {RED, RED};
      endcase
      return l;
   endfunction

endpackage

// File: rtl/tl_phase_timer.sv
// Saturating phase-duration counter: cleared on a phase change, counts while enabled.
module tl_phase_timer #(
   parameter int WIDTH = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             enable,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_r;

   // Count register with clear priority and saturation at all-ones.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_r <= '0;
      end else if (clear) begin
         count_r <= '0;
      end else if (enable && (count_r != {WIDTH{1'b1}})) begin
         count_r <= count_r + WIDTH'(1);
      end else begin
         count_r <= count_r;
      end
   end

   assign count = count_r;

endmodule

// File: rtl/traffic_light_timed_chk.sv
// Safety checker: no conflicting lamp pair outside flashing mode.
module traffic_light_timed_chk
   import traffic_pkg::*;
(
   input logic       clk,
   input logic       rst,
   input logic [1:0] hghwy,
   input logic [1:0] cntry,
   input logic [2:0] phase
);

   a_no_conflict: assert property (@(posedge clk) disable iff (!rst)
      (phase != 3'd6) |-> ((hghwy == RED) || (cntry == RED)))
      else $error("traffic_light_timed: conflicting lamps outside flash mode");

   a_flash_lamps: assert property (@(posedge clk) disable iff (!rst)
      (phase == 3'd6) |-> ((hghwy == cntry) && ((hghwy == YELLOW) || (hghwy == OFF))))
      else $error("traffic_light_timed: illegal lamp pattern in flash mode");

endmodule

// File: rtl/traffic_light_timed.sv
// Timed highway/country intersection controller with minimum/maximum greens,
// flashing night mode and a country-green timeout pulse.
module traffic_light_timed
   import traffic_pkg::*;
#(
   parameter int MIN_HWY_GREEN   = 8,
   parameter int YELLOW_CYCLES   = 3,
   parameter int ALLRED_CYCLES   = 2,
   parameter int MIN_CNTRY_GREEN = 4,
   parameter int MAX_CNTRY_GREEN = 16,
   parameter int FLASH_HALF      = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       x,
   input  logic       flash,
   output logic [1:0] hghwy,
   output logic [1:0] cntry,
   output logic [2:0] phase,
   output logic       timeout
);

   localparam int MAX_P = max_f(max_f(max_f(MIN_HWY_GREEN, YELLOW_CYCLES), max_f(ALLRED_CYCLES, MIN_CNTRY_GREEN)),
                                max_f(MAX_CNTRY_GREEN, FLASH_HALF));
   localparam int TW = clog2_f(MAX_P + 1);
   localparam int FW = clog2_f(FLASH_HALF + 1);

   localparam logic [TW-1:0] T_HG_MIN = TW'(MIN_HWY_GREEN - 1);
   localparam logic [TW-1:0] T_YEL    = TW'(YELLOW_CYCLES - 1);
   localparam logic [TW-1:0] T_AR     = TW'(ALLRED_CYCLES - 1);
   localparam logic [TW-1:0] T_CG_MIN = TW'(MIN_CNTRY_GREEN - 1);
   localparam logic [TW-1:0] T_CG_MAX = TW'(MAX_CNTRY_GREEN - 1);
   localparam logic [FW-1:0] F_LAST   = FW'(FLASH_HALF - 1);

   if ((MIN_HWY_GREEN < 1) || (YELLOW_CYCLES < 1) || (ALLRED_CYCLES < 1) ||
       (MIN_CNTRY_GREEN < 1) || (MAX_CNTRY_GREEN < 1) || (FLASH_HALF < 1)) begin : g_bad_min
      $error("traffic_light_timed: every timing parameter must be >= 1");
   end
   if (MIN_CNTRY_GREEN > MAX_CNTRY_GREEN) begin : g_bad_cntry
      $error("traffic_light_timed: MIN_CNTRY_GREEN exceeds MAX_CNTRY_GREEN");
   end

   state_t          state_r, state_s;
   logic [TW-1:0]   t_s;
   logic            clear_s;
   logic [FW-1:0]   fl_cnt_r, fl_cnt_s;
   logic            fl_off_r, fl_off_s;
   logic [1:0]      hghwy_r, cntry_r;
   logic [3:0]      lamps_s;
   logic            timeout_r, timeout_s;

   tl_phase_timer #(.WIDTH(TW)) u_timer (
      .clk    (clk),
      .rst    (rst),
      .clear  (clear_s),
      .enable (1'b1),
      .count  (t_s)
   );

   // Next-state, flash-pattern and lamp decode; lamps are registered from the next state.
   always_comb begin
      state_s   = state_r;
      timeout_s = 1'b0;
      fl_cnt_s  = '0;
      fl_off_s  = 1'b0;
      case (state_r)
         HG: begin
            if (flash || (x && (t_s >= T_HG_MIN))) state_s = HY;
            else                                    state_s = HG;
         end
         HY: begin
            if (t_s == T_YEL) state_s = AR1;
            else              state_s = HY;
         end
         AR1: begin
            if (t_s == T_AR) state_s = flash ? FL : CG;
            else             state_s = AR1;
         end
         CG: begin
            // Timeout is tested first so the pulse is issued even when flash coincides.
            if (t_s == T_CG_MAX) begin
               state_s   = CY;
               timeout_s = 1'b1;
            end else if (flash || (!x && (t_s >= T_CG_MIN))) begin
               state_s = CY;
            end else begin
               state_s = CG;
            end
         end
         CY: begin
            if (t_s == T_YEL) state_s = AR2;
            else              state_s = CY;
         end
         AR2: begin
            if (t_s == T_AR) state_s = flash ? FL : HG;
            else             state_s = AR2;
         end
         FL: begin
            if (flash) state_s = FL;
            else       state_s = AR2;
         end
         default: state_s = AR2;
      endcase

      clear_s = (state_s != state_r);

      if ((state_s == FL) && (state_r == FL)) begin
         if (fl_cnt_r == F_LAST) begin
            fl_cnt_s = '0;
            fl_off_s = ~fl_off_r;
         end else begin
            fl_cnt_s = fl_cnt_r + FW'(1);
            fl_off_s = fl_off_r;
         end
      end else begin
         fl_cnt_s = '0;
         fl_off_s = 1'b0;
      end

      lamps_s = lamps_f(state_s, fl_off_s);
   end

   // State, flash pattern and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r   <= AR2;
         fl_cnt_r  <= '0;
         fl_off_r  <= 1'b0;
         hghwy_r   <= RED;
         cntry_r   <= RED;
         timeout_r <= 1'b0;
      end else begin
         state_r   <= state_s;
         fl_cnt_r  <= fl_cnt_s;
         fl_off_r  <= fl_off_s;
         hghwy_r   <= lamps_s[3:2];
         cntry_r   <= lamps_s[1:0];
         timeout_r <= timeout_s;
      end
   end

   assign hghwy   = hghwy_r;
   assign cntry   = cntry_r;
   assign phase   = state_r;
   assign timeout = timeout_r;

   traffic_light_timed_chk u_chk (
      .clk   (clk),
      .rst   (rst),
      .hghwy (hghwy),
      .cntry (cntry),
      .phase (phase)
   );

endmodule

// File: tb/tb_traffic_light_timed.sv
// Scoreboard bench for traffic_light_timed: the driver queues per-cycle
// expectations, a monitor compares them one cycle at a time.
module tb_traffic_light_timed;

   localparam logic [2:0] P_HG = 3'd0, P_HY = 3'd1, P_AR1 = 3'd2, P_CG = 3'd3,
                          P_CY = 3'd4, P_AR2 = 3'd5, P_FL = 3'd6;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       x = 1'b0;
   logic       flash = 1'b0;
   logic [1:0] hghwy, cntry;
   logic [2:0] phase;
   logic       timeout;

   typedef struct packed {
      logic [1:0] h;
      logic [1:0] c;
      logic [2:0] p;
      logic       to;
   } exp_t;

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;

   traffic_light_timed dut (
      .clk     (clk),
      .rst     (rst),
      .x       (x),
      .flash   (flash),
      .hghwy   (hghwy),
      .cntry   (cntry),
      .phase   (phase),
      .timeout (timeout)
   );

   always #5 clk = ~clk;

   function automatic exp_t mk(input logic [2:0] p, input logic off, input logic to);
      exp_t e;
      e.p  = p;
      e.to = to;
      case (p)
         P_HG:    begin e.h = 2'd2; e.c = 2'd0; end
         P_HY:    begin e.h = 2'd1; e.c = 2'd0; end
         P_CG:    begin e.h = 2'd0; e.c = 2'd2; end
         P_CY:    begin e.h = 2'd0; e.c = 2'd1; end
         P_FL:    begin e.h = off ? 2'd3 : 2'd1; e.c = off ? 2'd3 : 2'd1; end
         default: begin e.h = 2'd0; e.c = 2'd0; end
      endcase
      return e;
   endfunction

   // n cycles with given inputs; expectation is the state after each edge.
   task automatic run(input int n, input logic xi, input logic fi, input logic [2:0] p,
                      input logic to = 1'b0, input logic off = 1'b0);
      for (int i = 0; i < n; i++) begin
         x     = xi;
         flash = fi;
         q.push_back(mk(p, off, (i == 0) ? to : 1'b0));
         @(negedge clk);
      end
   endtask

   task automatic do_reset();
      rst   = 1'b0;
      x     = 1'b0;
      flash = 1'b0;
      #1;
      tests++;
      if ({hghwy, cntry, phase, timeout} !== {2'd0, 2'd0, 3'd5, 1'b0}) begin
         fails++;
         $display("FAIL reset: got h=%0d c=%0d phase=%0d to=%0d, required h=0 c=0 phase=5 to=0",
                  hghwy, cntry, phase, timeout);
      end
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            tests++;
            if ({hghwy, cntry, phase, timeout} !== e) begin
               fails++;
               $display("FAIL cycle @%0t: got h=%0d c=%0d phase=%0d to=%0d, required h=%0d c=%0d phase=%0d to=%0d",
                        $time, hghwy, cntry, phase, timeout, e.h, e.c, e.p, e.to);
            end
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin : driver
      @(negedge clk);

      // Idle after reset: all-red clearance, then highway green held.
      do_reset();
      run(1, 1'b0, 1'b0, P_AR2);
      run(20, 1'b0, 1'b0, P_HG);

      // Country demand held: minimum highway green, then country timeout.
      do_reset();
      run(1, 1'b0, 1'b0, P_AR2);
      run(1, 1'b0, 1'b0, P_HG);
      run(7, 1'b1, 1'b0, P_HG);
      run(3, 1'b1, 1'b0, P_HY);
      run(2, 1'b1, 1'b0, P_AR1);
      run(16, 1'b1, 1'b0, P_CG);
      run(1, 1'b1, 1'b0, P_CY, 1'b1);
      run(2, 1'b1, 1'b0, P_CY);
      run(2, 1'b1, 1'b0, P_AR2);
      run(3, 1'b1, 1'b0, P_HG);

      // Demand drops after two country-green cycles: minimum country green.
      do_reset();
      run(1, 1'b0, 1'b0, P_AR2);
      run(1, 1'b0, 1'b0, P_HG);
      run(7, 1'b1, 1'b0, P_HG);
      run(3, 1'b1, 1'b0, P_HY);
      run(2, 1'b1, 1'b0, P_AR1);
      run(1, 1'b1, 1'b0, P_CG);
      run(2, 1'b1, 1'b0, P_CG);
      run(1, 1'b0, 1'b0, P_CG);
      run(3, 1'b0, 1'b0, P_CY);
      run(2, 1'b0, 1'b0, P_AR2);
      run(2, 1'b0, 1'b0, P_HG);

      // Short demand pulse before the minimum is not latched.
      do_reset();
      run(1, 1'b0, 1'b0, P_AR2);
      run(1, 1'b0, 1'b0, P_HG);
      run(3, 1'b0, 1'b0, P_HG);
      run(1, 1'b1, 1'b0, P_HG);
      run(15, 1'b0, 1'b0, P_HG);

      // Flash request in highway green, flashing pattern, then back to highway.
      do_reset();
      run(1, 1'b0, 1'b0, P_AR2);
      run(1, 1'b0, 1'b0, P_HG);
      run(1, 1'b0, 1'b0, P_HG);
      run(3, 1'b0, 1'b1, P_HY);
      run(2, 1'b0, 1'b1, P_AR1);
      run(4, 1'b1, 1'b1, P_FL, 1'b0, 1'b0);
      run(4, 1'b1, 1'b1, P_FL, 1'b0, 1'b1);
      run(4, 1'b0, 1'b1, P_FL, 1'b0, 1'b0);
      run(2, 1'b0, 1'b1, P_FL, 1'b0, 1'b1);
      run(2, 1'b0, 1'b0, P_AR2);
      run(3, 1'b0, 1'b0, P_HG);

      // Asynchronous reset in the middle of country green.
      do_reset();
      run(1, 1'b0, 1'b0, P_AR2);
      run(1, 1'b0, 1'b0, P_HG);
      run(7, 1'b1, 1'b0, P_HG);
      run(3, 1'b1, 1'b0, P_HY);
      run(2, 1'b1, 1'b0, P_AR1);
      run(5, 1'b1, 1'b0, P_CG);
      do_reset();
      run(1, 1'b0, 1'b0, P_AR2);
      run(3, 1'b0, 1'b0, P_HG);

      @(negedge clk);
      @(negedge clk);
      tests++;
      if (q.size() != 0) begin
         fails++;
         $display("FAIL drain: got %0d pending expectations, required 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/traffic_light_timed.md
Name: traffic_light_timed

Overview:
- Parametrised successor of the highway/country intersection controller.
- Dwell times are generated by an internal synthesizable phase timer; there are no behavioural delays.
- Adds minimum-green guarantees, a country max-green timeout, a flashing night/fault mode and a phase status output.
- Sits between the road sensor input (x) and the lamp drivers for both roads.

Parameters:
- MIN_HWY_GREEN, 8: minimum cycles in highway green before a country request is honoured.
- YELLOW_CYCLES, 3: cycles spent in each yellow phase.
- ALLRED_CYCLES, 2: cycles spent in each all-red clearance phase.
- MIN_CNTRY_GREEN, 4: minimum cycles in country green.
- MAX_CNTRY_GREEN, 16: country green timeout in cycles.
- FLASH_HALF, 4: cycles per half-period of the flashing-yellow pattern.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- x  input  1  country-road vehicle present, synchronous level.
- flash  input  1  flashing-mode request, synchronous level.
- hghwy  output  2  highway lamp colour.
- cntry  output  2  country lamp colour.
- phase  output  3  current state code.
- timeout  output  1  one-cycle pulse when country green is ended by MAX_CNTRY_GREEN.

Behaviour:
- Colour codes: RED=0, YELLOW=1, GREEN=2, OFF=3.
- Moore machine: hghwy, cntry and phase decode from the state register only; timeout is a registered pulse.
- States and codes: HG=0, HY=1, AR1=2, CG=3, CY=4, AR2=5, FL=6.
- Lamp outputs per state:
  - HG: hghwy GREEN, cntry RED.
  - HY: hghwy YELLOW, cntry RED.
  - AR1, AR2: both RED.
  - CG: hghwy RED, cntry GREEN.
  - CY: hghwy RED, cntry YELLOW.
  - FL: both YELLOW or both OFF.
- Reset (rst=0, asynchronous):
  - state=AR2, timer=0, both lamps RED, phase=5, timeout=0.
  - After release, both lamps stay RED for ALLRED_CYCLES cycles, then HG.
  - Reset asserted mid-operation forces all-red immediately.
- Timer:
  - Cleared to 0 on every state change; increments each cycle the state is held; saturates at its maximum.
  - Width is clog2(max parameter + 1).
  - "t" below is the timer value sampled at the edge.
- HG:
  - flash=1 -> HY, regardless of t.
  - Else x=1 and t>=MIN_HWY_GREEN-1 -> HY.
  - Else stay. x pulses before the minimum are not latched.
- HY: t==YELLOW_CYCLES-1 -> AR1.
- AR1: t==ALLRED_CYCLES-1 -> FL if flash=1, else CG.
- CG:
  - flash=1 -> CY.
  - Else t==MAX_CNTRY_GREEN-1 -> CY with timeout=1 for the next cycle. Timeout has priority over x.
  - Else x=0 and t>=MIN_CNTRY_GREEN-1 -> CY.
  - Else stay.
- CY: t==YELLOW_CYCLES-1 -> AR2.
- AR2: t==ALLRED_CYCLES-1 -> FL if flash=1, else HG.
- FL:
  - Both lamps YELLOW for FLASH_HALF cycles, then OFF for FLASH_HALF cycles, repeating; always starts with YELLOW.
  - x is ignored.
  - flash=0 -> AR2. The next green is always the highway.
- flash asserted during HY/CY/AR1/AR2: the current phase completes normally; the flash check is applied at the all-red exit.
- Simultaneous flash and timeout in CG: go to CY, timeout pulse still issued.
- Never both lamps GREEN or YELLOW/GREEN conflicting outside FL. An assertion is required in the implementation.
- Parameter legality (elaboration error if violated):
  - every parameter >= 1;
  - MIN_CNTRY_GREEN <= MAX_CNTRY_GREEN.

Decomposition:
- Shared package traffic_pkg holds:
  - colour constants RED/YELLOW/GREEN/OFF;
  - state encoding typedef (HG..FL);
  - a clog2 helper.
- One sub-module, tl_phase_timer: clear, enable, saturating count output, width parameter.
- Flash toggle counter lives in the top.

Test Plan:
1. Reset release, x=0, flash=0, defaults -> both RED for 2 cycles, then hghwy GREEN/cntry RED held indefinitely; phase=0.
2. x=1 from the first HG cycle -> HG held 8 cycles, HY 3, AR1 2, then cntry GREEN. With x held: CG lasts 16 cycles, timeout pulses once, then CY 3, AR2 2, HG.
3. x=1 at HG entry, dropped after 2 cycles of CG -> CG lasts exactly 4 cycles (minimum), no timeout pulse.
4. x pulse for 1 cycle at HG cycle 3 -> no transition; HG persists.
5. flash=1 asserted during HG cycle 2 -> HY next cycle, AR1 2 cycles, then FL with both YELLOW 4 / OFF 4 repeating. Deassert flash -> AR2 2 cycles, then HG.
6. rst pulled low during CG cycle 5 -> both RED in the same cycle (asynchronous), phase=5, timeout=0. After release, 2 RED cycles, then HG.
